// File: rtl/rsa_stream_host.sv
// rsa_stream_host: word-stream front end that loads and runs the rsa4k engine.
// Optional engine-reset pulse before each run: define RSA_HOST_ENG_RST_EN.
module rsa_stream_host #(
    parameter int WIDTH      = 4096,
    parameter int WORD       = 32,
    parameter int RST_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WORD-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORD-1:0]  out_data,
    output logic             out_last,
    output logic             busy,
    output logic             eng_reset,
    output logic             go,
    input  logic             done,
    input  logic [WIDTH-1:0] cypher,
    output logic [WIDTH-1:0] message,
    output logic [WIDTH-1:0] exponent,
    output logic [WIDTH-1:0] modulus
);
    localparam int N    = WIDTH / WORD;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int RW   = $clog2(RST_CYCLES + 1);
    // wide enough for word indices and the engine-reset pulse timer
    localparam int CNTW = (CW > RW) ? CW : RW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_MOD,
        S_LOAD_EXP,
        S_LOAD_MSG,
        S_ERST,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  mod_q, mod_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [WIDTH-1:0]  msg_q, msg_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CNTW-1:0]   widx;
    logic              acc;
    logic              load_st;

    assign load_st = (state_q == S_IDLE) || (state_q == S_LOAD_MOD) ||
                     (state_q == S_LOAD_EXP) || (state_q == S_LOAD_MSG);

    assign in_ready  = load_st && !reset;
    assign acc       = in_valid && in_ready;
    assign busy      = (state_q != S_IDLE);
    assign go        = (state_q == S_RUN);
    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = out_valid ? res_q[WORD-1:0] : '0;
    assign out_last  = out_valid && (cnt_q == CNTW'(N - 1));
    assign modulus   = mod_q;
    assign exponent  = exp_q;
    assign message   = msg_q;

    // modulus word 0 is taken in IDLE, so LOAD_MOD indices run one ahead
    assign widx = (state_q == S_LOAD_MOD) ? cnt_q + CNTW'(1) : cnt_q;

`ifdef RSA_HOST_ENG_RST_EN
    assign eng_reset = (state_q == S_ERST);
`else
    assign eng_reset = 1'b0;
`endif

    // next-state, operand assembly and result shifting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mod_d   = mod_q;
        exp_d   = exp_q;
        msg_d   = msg_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    mod_d[WORD-1:0] = in_data;
                    state_d = S_LOAD_MOD;
                end
            end
            S_LOAD_MOD: begin
                if (acc) begin
                    for (int k = 0; k < N; k++)
                        if (widx == CNTW'(k)) mod_d[k*WORD +: WORD] = in_data;
                    cnt_d = cnt_q + CNTW'(1);
                    if (widx == CNTW'(N - 1)) state_d = S_LOAD_EXP;
                end
            end
            S_LOAD_EXP: begin
                if (acc) begin
                    for (int k = 0; k < N; k++)
                        if (widx == CNTW'(k)) exp_d[k*WORD +: WORD] = in_data;
                    cnt_d = cnt_q + CNTW'(1);
                    if (widx == CNTW'(N - 1)) state_d = S_LOAD_MSG;
                end
            end
            S_LOAD_MSG: begin
                if (acc) begin
                    for (int k = 0; k < N; k++)
                        if (widx == CNTW'(k)) msg_d[k*WORD +: WORD] = in_data;
                    cnt_d = cnt_q + CNTW'(1);
`ifdef RSA_HOST_ENG_RST_EN
                    if (widx == CNTW'(N - 1)) state_d = S_ERST;
`else
                    if (widx == CNTW'(N - 1)) state_d = S_RUN;
`endif
                end
            end
`ifdef RSA_HOST_ENG_RST_EN
            S_ERST: begin
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(RST_CYCLES - 1)) state_d = S_RUN;
            end
`endif
            S_RUN: begin
                if (done) begin
                    res_d   = cypher;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    res_d = res_q >> WORD;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(N - 1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mod_q   <= '0;
            exp_q   <= '0;
            msg_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mod_q   <= mod_d;
            exp_q   <= exp_d;
            msg_q   <= msg_d;
            res_q   <= res_d;
        end
    end
endmodule
